// File: rtl/div_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// div_ratio_ctrl
//
// Glitch-free ratio switcher for a downstream clock divider. A new ratio is
// never applied while the divider is enabled. The enable is dropped only just
// after a falling edge of the fed-back divided clock, so the divider stops in
// its low phase. A forced switch happens if no falling edge arrives within
// TIMEOUT cycles. The enable then stays low for GAP cycles. The ratio is
// loaded next, and the requested enable is restored one cycle after that.
//
// Ports
//   clk         system clock, all logic on its rising edge
//   reset       asynchronous, active-high reset
//   cfg_valid   configuration request present
//   cfg_ratio   requested division ratio (values below 2 are rejected)
//   cfg_enable  requested divider enable after the switch
//   cfg_ready   request accepted on an edge where cfg_valid and cfg_ready are 1
//   div_clk     divided clock fed back from the divider (synchronous to clk)
//   o_div_ratio ratio driven to the divider
//   o_enable    enable driven to the divider
//   o_busy      switch sequence in progress (~cfg_ready)
//   o_err       one-cycle pulse on a rejected request or a drain timeout
//   dbg_state   current controller state, for observation only
//
// Handshake: a request transfers on a rising clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready depends only on the controller state and
// never on cfg_valid. cfg_valid seen while cfg_ready is 0 is ignored and
// has no effect.
// -----------------------------------------------------------------------------
module div_ratio_ctrl #(
    parameter int WIDTH   = 8,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_ratio,
    input  logic             cfg_enable,
    output logic             cfg_ready,
    input  logic             div_clk,
    output logic [WIDTH-1:0] o_div_ratio,
    output logic             o_enable,
    output logic             o_busy,
    output logic             o_err,
    output logic [2:0]       dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [TW-1:0]    TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]    GAP_LAST    = GW'(GAP - 1);
    localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GAP   = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ratio_d;
    logic             enable_d;
    logic             err_d;
    logic [WIDTH-1:0] pend_ratio_q, pend_ratio_d;
    logic             pend_en_q, pend_en_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             div_clk_q;

    logic accept;
    logic ratio_ok;
    logic div_fall;

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign o_busy    = ~cfg_ready;
    assign dbg_state = state_q;

    assign accept   = cfg_valid & cfg_ready;
    assign ratio_ok = cfg_ratio > WIDTH'(1);
    // div_clk_q holds the previous sample and div_clk is the current one.
    assign div_fall = div_clk_q & ~div_clk;

    always_comb begin
        state_d      = state_q;
        ratio_d      = o_div_ratio;
        enable_d     = o_enable;
        err_d        = 1'b0;
        pend_ratio_d = pend_ratio_q;
        pend_en_d    = pend_en_q;
        to_cnt_d     = to_cnt_q;
        gap_cnt_d    = gap_cnt_q;

        // Requests are only accepted in IDLE and RUN.
        if (accept) begin
            if (!ratio_ok) begin
                err_d = 1'b1;
            end else begin
                pend_ratio_d = cfg_ratio;
                pend_en_d    = cfg_enable;
                if (state_q == ST_IDLE) begin
                    // The divider is already stopped, so the ratio can be
                    // applied immediately.
                    state_d = ST_LOAD;
                    ratio_d = cfg_ratio;
                end else if (!((cfg_ratio == o_div_ratio) && cfg_enable)) begin
                    // Same ratio with enable kept on needs no stop at all.
                    state_d  = ST_DRAIN;
                    to_cnt_d = '0;
                end
            end
        end

        case (state_q)
            ST_DRAIN: begin
                if (div_fall || (to_cnt_q == TO_LAST)) begin
                    enable_d  = 1'b0;
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    err_d     = ~div_fall;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    // The enable is low here, so changing the ratio is safe.
                    state_d = ST_LOAD;
                    ratio_d = pend_ratio_q;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_LOAD: begin
                enable_d = pend_en_q;
                state_d  = pend_en_q ? ST_RUN : ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            o_div_ratio  <= RESET_RATIO;
            o_enable     <= 1'b0;
            o_err        <= 1'b0;
            pend_ratio_q <= '0;
            pend_en_q    <= 1'b0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            div_clk_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_div_ratio  <= ratio_d;
            o_enable     <= enable_d;
            o_err        <= err_d;
            pend_ratio_q <= pend_ratio_d;
            pend_en_q    <= pend_en_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            div_clk_q    <= div_clk;
        end
    end

endmodule
